// File: rtl/mux_sched_pkg.sv
// Shared constants and FSM encoding for the round-robin mux scheduler.
package mux_sched_pkg;

    localparam int NUM_REQ   = 31;
    localparam int SEL_W     = 5;
    localparam int DATA_W    = 2;
    localparam int MAX_BURST = 4;
    localparam int CNT_W     = 4;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

endpackage

// File: rtl/mux_rr_scheduler_rr_pick.sv
// Rotating-priority encoder: the first requester strictly after last_owner,
// wrapping from NUM_REQ-1 back to 0.
module rr_pick
    import mux_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last_owner,
    output logic               found,
    output logic [SEL_W-1:0]   index
);

    logic [SEL_W-1:0]   cand_idx [NUM_REQ];
    logic [NUM_REQ-1:0] cand_hit;

    // Candidate gi is the requester gi+1 places after last_owner; one subtraction
    // is enough because last_owner + gi + 1 < 2*NUM_REQ.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_cand
            logic [SEL_W:0] sum;
            assign sum = {1'b0, last_owner} + (SEL_W+1)'(gi + 1);
            assign cand_idx[gi] = (sum >= (SEL_W+1)'(NUM_REQ))
                                ? SEL_W'(sum - (SEL_W+1)'(NUM_REQ))
                                : sum[SEL_W-1:0];
            assign cand_hit[gi] = req[cand_idx[gi]];
        end
    endgenerate

    always_comb begin
        found = |cand_hit;
        index = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (cand_hit[k]) begin
                index = cand_idx[k];
            end
        end
    end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler that sequences the select of the 31:1 mux and forwards
// each captured beat through a single-slot registered valid/ready output.
module mux_rr_scheduler
    import mux_sched_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_valid,
    output logic [NUM_REQ-1:0] req_ready,
    output logic [SEL_W-1:0]   mux_sel,
    input  logic [DATA_W-1:0]  mux_out,
    output logic               out_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic [SEL_W-1:0]   out_src,
    input  logic               out_ready,
    output logic               busy
);

    state_t              state_reg;
    logic [SEL_W-1:0]    mux_sel_reg;
    logic [SEL_W-1:0]    last_owner_reg;
    logic [CNT_W-1:0]    beat_cnt_reg;
    logic                out_valid_reg;
    logic [DATA_W-1:0]   out_data_reg;
    logic [SEL_W-1:0]    out_src_reg;

    logic                pick_found;
    logic [SEL_W-1:0]    pick_idx;
    logic                owner_valid;
    logic                can_take;
    logic                last_beat;

    rr_pick u_pick (
        .req        (req_valid),
        .last_owner (last_owner_reg),
        .found      (pick_found),
        .index      (pick_idx)
    );

    assign owner_valid = req_valid[mux_sel_reg];
    assign can_take    = (state_reg == XFER) && owner_valid
                       && (!out_valid_reg || out_ready);
    assign last_beat   = (beat_cnt_reg == CNT_W'(MAX_BURST - 1));

    assign req_ready = can_take ? (NUM_REQ'(1) << mux_sel_reg) : '0;
    assign mux_sel   = mux_sel_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_src   = out_src_reg;
    assign busy      = (state_reg == XFER);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            mux_sel_reg    <= '0;
            last_owner_reg <= SEL_W'(NUM_REQ - 1);
            beat_cnt_reg   <= '0;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_src_reg    <= '0;
        end else begin
            // The output slot drains in either state so a beat is never presented twice.
            if (can_take) begin
                out_data_reg  <= mux_out;
                out_src_reg   <= mux_sel_reg;
                out_valid_reg <= 1'b1;
                beat_cnt_reg  <= beat_cnt_reg + CNT_W'(1);
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (pick_found) begin
                        mux_sel_reg  <= pick_idx;
                        beat_cnt_reg <= '0;
                        state_reg    <= XFER;
                    end
                end
                XFER: begin
                    if ((can_take && last_beat) || !owner_valid) begin
                        last_owner_reg <= mux_sel_reg;
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Directed and randomized bench for mux_rr_scheduler with a behavioural reference
// model of the round-robin grant and single-slot output rules.
module tb_mux_rr_scheduler;
    import mux_sched_pkg::*;

    logic               clk = 1'b0;
    logic               reset;
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic [SEL_W-1:0]   mux_sel;
    logic [DATA_W-1:0]  mux_out;
    logic               out_valid;
    logic [DATA_W-1:0]  out_data;
    logic [SEL_W-1:0]   out_src;
    logic               out_ready;
    logic               busy;

    logic [DATA_W-1:0]  req_data [NUM_REQ];

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int  m_owner;   // -1 when no grant is held
    int  m_sel;
    int  m_last;
    int  m_cnt;
    bit  m_ov;
    int  m_od;
    int  m_os;

    bit  prev_busy = 1'b0;
    int  grants[$];

    always #5 clk = ~clk;

    // the mux datapath itself: input i appears on mux_out when selected
    assign mux_out = (mux_sel < SEL_W'(NUM_REQ)) ? req_data[mux_sel] : '0;

    mux_rr_scheduler dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .mux_sel   (mux_sel),
        .mux_out   (mux_out),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_sel   = 0;
        m_last  = NUM_REQ - 1;
        m_cnt   = 0;
        m_ov    = 1'b0;
        m_od    = 0;
        m_os    = 0;
    endtask

    // One clock: compare at the falling edge, advance the model, return 1ns after the rising edge.
    task automatic tick();
        bit                 take;
        logic [NUM_REQ-1:0] exp_rdy;
        @(negedge clk);
        take    = (m_owner >= 0) && req_valid[m_sel] && (!m_ov || out_ready);
        exp_rdy = '0;
        if (take) exp_rdy[m_sel] = 1'b1;
        chk("mux_sel",   32'(mux_sel),   32'(m_sel));
        chk("busy",      32'(busy),      32'(m_owner >= 0));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("out_data",  32'(out_data),  32'(m_od));
        chk("out_src",   32'(out_src),   32'(m_os));
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (busy === 1'b1 && !prev_busy) grants.push_back(int'(mux_sel));
        prev_busy = (busy === 1'b1);

        if (reset) begin
            model_reset();
        end else begin
            if (take) begin
                m_ov = 1'b1;
                m_od = int'(req_data[m_sel]);
                m_os = m_sel;
            end else if (m_ov && out_ready) begin
                m_ov = 1'b0;
            end
            if (m_owner < 0) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    int i;
                    i = (m_last + k) % NUM_REQ;
                    if (req_valid[i] && m_owner < 0) begin
                        m_owner = i;
                        m_sel   = i;
                        m_cnt   = 0;
                    end
                end
            end else if (!req_valid[m_sel] || (take && m_cnt == MAX_BURST - 1)) begin
                m_last  = m_sel;
                m_owner = -1;
            end else if (take) begin
                m_cnt++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int j = 0; j < n; j++) tick();
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '1;
        out_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) req_data[i] = DATA_W'(i + 2);
        model_reset();
        @(posedge clk);
        #1;

        // 1: reset held with every requester asserting
        ticks(2);
        reset     = 1'b0;
        req_valid = '0;
        ticks(2);

        // 2: single requester 0, continuous, re-granted after each idle cycle
        grants.delete();
        req_valid = NUM_REQ'(1);
        ticks(10);
        chk("t2_grant0", 32'(grants[0]), 32'd0);
        chk("t2_grant1", 32'(grants[1]), 32'd0);
        req_valid = '0;
        ticks(3);

        // 3: requesters 5 and 30 alternate, search wraps past 30 back to 5
        grants.delete();
        req_valid = '0;
        req_valid[5]  = 1'b1;
        req_valid[30] = 1'b1;
        ticks(24);
        chk("t3_grant0", 32'(grants[0]), 32'd5);
        chk("t3_grant1", 32'(grants[1]), 32'd30);
        chk("t3_grant2", 32'(grants[2]), 32'd5);
        chk("t3_grant3", 32'(grants[3]), 32'd30);
        req_valid = '0;
        ticks(3);

        // 4: owner 7 stalled by downstream for 3 cycles mid-burst
        req_valid    = '0;
        req_valid[7] = 1'b1;
        ticks(3);
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            chk("t4_hold_valid", 32'(out_valid), 32'd1);
            chk("t4_hold_src",   32'(out_src),   32'd7);
            chk("t4_hold_data",  32'(out_data),  32'(req_data[7]));
            chk("t4_no_ready",   32'(req_ready), 32'd0);
        end
        out_ready = 1'b1;
        ticks(6);
        req_valid = '0;
        ticks(3);

        // 5: owner 12 drops after 2 beats, next grant goes above 12 (to 20)
        grants.delete();
        req_valid     = '0;
        req_valid[3]  = 1'b1;
        req_valid[12] = 1'b1;
        req_valid[20] = 1'b1;
        ticks(3);
        req_valid[12] = 1'b0;
        ticks(5);
        chk("t5_grant0", 32'(grants[0]), 32'd12);
        chk("t5_grant1", 32'(grants[1]), 32'd20);
        req_valid = '0;
        ticks(4);

        // 6: reset lands mid-burst from requester 3
        req_valid    = '0;
        req_valid[3] = 1'b1;
        ticks(3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_mux_sel",   32'(mux_sel),   32'd0);
        chk("t6_busy",      32'(busy),      32'd0);
        grants.delete();
        ticks(3);
        chk("t6_regrant", 32'(grants[0]), 32'd3);

        // randomized traffic, backpressure and occasional reset
        for (int c = 0; c < 800; c++) begin
            tick();
            for (int i = 0; i < NUM_REQ; i++) begin
                if ($urandom_range(15) == 0) req_valid[i] = ~req_valid[i];
                req_data[i] = DATA_W'($urandom);
            end
            if (c % 200 == 100) req_valid = '0;
            out_ready = ($urandom_range(3) != 0);
            reset     = ($urandom_range(149) == 0);
        end
        reset = 1'b0;
        ticks(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
